risc_v_mc_control: RTL and testbench
====================================

RISC_V_MC_CONTROL -- requirements
Module: risc_v_mc_control

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 255: maximum consecutive wait cycles on MemReady before fault.
REQ-002 SHALL have port CLK input 1: the single clock; all state updates on posedge.
REQ-003 SHALL have port ResetN input 1: asynchronous, active-low reset.
REQ-004 SHALL have port Instr input 32: instruction register contents (opcode [6:0], funct3 [14:12], funct7b5 [30]).
REQ-005 SHALL have port Zero input 1 and port Negative input 1: ALU flags of the current cycle.
REQ-006 SHALL have port MemReady input 1: shared memory completes the current access this cycle.
REQ-007 SHALL have ports PCWrite, IRWrite, RegWrite, MemWrite output 1: register and memory enables.
REQ-008 SHALL have port AdrSrc output 1: memory address, 0 = PC, 1 = ALUOut.
REQ-009 SHALL have ports ALUSrcA output 2 (00 PC, 01 OldPC, 10 RD1) and ALUSrcB output 2 (00 RD2, 01 ImmExt, 10 constant 4).
REQ-010 SHALL have port ResultSrc output 2: 00 ALUOut, 01 memory data, 10 ALUResult, 11 ImmExt.
REQ-011 SHALL have port ImmSrc output 3 (000 I, 001 S, 010 B, 011 U, 100 J) and port ALUControl output 5.
REQ-012 SHALL have port InstrDone output 1 (one-cycle retire pulse) and port Fault output 1 (sticky).

Function
REQ-013 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALRWB, LUI, ERROR; outputs default to 0 and ALUControl to add (00010) unless stated.
REQ-014 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10; IRWrite and PCWrite equal MemReady; stay until MemReady, then DECODE.
REQ-015 DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc per opcode; next state by opcode: 0000011/0100011 MEMADR, 0110011 EXECR, 0010011 EXECI, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111 LUI, any other ERROR.
REQ-016 MEMADR: ALUSrcA=10, ALUSrcB=01, ImmSrc S for store else I; next MEMWRITE for store, MEMREAD for load.
REQ-017 MEMREAD: AdrSrc=1; hold until MemReady, then MEMWB; MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
REQ-018 MEMWRITE: AdrSrc=1, MemWrite=1 held every cycle until MemReady, then FETCH.
REQ-019 EXECR: ALUSrcA=10, ALUSrcB=00; EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc I; both then ALUWB.
REQ-020 ALU decode: funct3 000 add (sub 01010 when EXECR and funct7b5=1), 110 or 00111, 111 and 00011, 001 sll 00000, 101 srl 10000, 010 slt 00001, others add.
REQ-021 ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
REQ-022 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUControl sub, ResultSrc=00; PCWrite = beq Zero, bne !Zero, blt Negative, bge !Negative, other funct3 0; then FETCH.
REQ-023 JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, ImmSrc J, PCWrite=1; then ALUWB.
REQ-024 JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc I, ResultSrc=10, PCWrite=1; JALRWB: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, RegWrite=1; then FETCH.
REQ-025 LUI: ImmSrc U, ResultSrc=11, RegWrite=1; then FETCH.
REQ-026 InstrDone SHALL pulse on the final cycle of each instruction (the cycle leaving for FETCH).
REQ-027 Wait counter SHALL clear on entry to FETCH/MEMREAD/MEMWRITE and on MemReady, increment per stalled cycle; reaching STALL_LIMIT SHALL enter ERROR.
REQ-028 ERROR: Fault=1, all enables 0, no exit except reset.
REQ-029 Latency with MemReady held 1: R/I/JAL/JALR/sw 4 cycles, lw 5, branch/LUI 3.

Reset
REQ-030 ResetN low SHALL immediately force state FETCH, wait counter 0, Fault 0; all outputs then take FETCH values, independent of CLK.
REQ-031 Reset asserted mid-instruction (including during MemWrite) SHALL abandon it; no enable is asserted after reset until FETCH with MemReady.

Structure
REQ-032 Package risc_v_pkg SHALL hold the state enum, opcode constants, ALUControl codes, ImmSrc and source-select encodings.
REQ-033 ALU decoding SHALL be sub-module risc_v_alu_decoder (funct3, funct7b5, IsRType, IsBranch -> ALUControl).

Verification
REQ-034 add x3,x1,x2 (0x002081B3), MemReady=1 -> states FETCH,DECODE,EXECR,ALUWB; ALUControl 00010 in EXECR; RegWrite only cycle 4; InstrDone cycle 4.
REQ-035 lw with MemReady low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, MemWrite 0, RegWrite only in MEMWB, total 8 cycles.
REQ-036 beq (funct3 000) with Zero=1 then Zero=0 -> PCWrite 1 in BRANCH first run, 0 second; 3 cycles each.
REQ-037 opcode 0x7F -> ERROR after DECODE, Fault=1 sticky; ResetN low clears to FETCH asynchronously.
REQ-038 STALL_LIMIT=4, MemReady held 0 in FETCH -> ERROR after 4 stalled cycles, IRWrite never asserted.
REQ-039 ResetN pulsed low during MEMWRITE -> MemWrite drops immediately, FETCH resumes on release.

Source files
------------

// File: rtl/risc_v_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states,
// opcodes, ALU operation codes, immediate formats and datapath mux selects.
package risc_v_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALRWB   = 4'd12,
        S_LUI      = 4'd13,
        S_ERROR    = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b01010;
    localparam logic [4:0] ALU_OR  = 5'b00111;
    localparam logic [4:0] ALU_AND = 5'b00011;
    localparam logic [4:0] ALU_SLL = 5'b00000;
    localparam logic [4:0] ALU_SRL = 5'b10000;
    localparam logic [4:0] ALU_SLT = 5'b00001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    // Immediate format the decode cycle must present for a given opcode
    // (instructions without an immediate fall back to the I format).
    function automatic logic [2:0] imm_src_for(input logic [6:0] opcode);
        case (opcode)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_LUI:    return IMM_U;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/risc_v_alu_decoder.sv
// Maps funct3/funct7b5 to an ALU operation. Branches always compare by
// subtraction; only register-register instructions may select sub.
module risc_v_alu_decoder
    import risc_v_pkg::*;
(
    input  logic [2:0] Funct3,
    input  logic       Funct7b5,
    input  logic       IsRType,
    input  logic       IsBranch,
    output logic [4:0] ALUControl
);

    // Pure combinational operation select.
    always_comb begin
        ALUControl = ALU_ADD;
        if (IsBranch) begin
            ALUControl = ALU_SUB;
        end else begin
            case (Funct3)
                3'b000:  ALUControl = (IsRType && Funct7b5) ? ALU_SUB : ALU_ADD;
                3'b110:  ALUControl = ALU_OR;
                3'b111:  ALUControl = ALU_AND;
                3'b001:  ALUControl = ALU_SLL;
                3'b101:  ALUControl = ALU_SRL;
                3'b010:  ALUControl = ALU_SLT;
                default: ALUControl = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/risc_v_mc_control.sv
// Multicycle RISC-V control FSM. Outputs are decoded from the current state
// only, qualified by this cycle's MemReady/Zero/Negative where noted.
// Memory handshake: in FETCH, MEMREAD and MEMWRITE the access is presented
// every cycle and completes in the cycle MemReady is 1; a run of
// STALL_LIMIT cycles with MemReady low is treated as a dead memory (ERROR).
module risc_v_mc_control
    import risc_v_pkg::*;
#(
    parameter int STALL_LIMIT = 255
) (
    input  logic        CLK,
    input  logic        ResetN,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        Negative,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [2:0]  ImmSrc,
    output logic [4:0]  ALUControl,
    output logic        InstrDone,
    output logic        Fault,
    output logic [3:0]  DbgState
);

    localparam int CW = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STALL_LIMIT - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stall;
    logic [4:0]    dec_alu;

    wire  [6:0] opcode   = Instr[6:0];
    wire  [2:0] funct3   = Instr[14:12];
    wire        funct7b5 = Instr[30];
    logic       unused_instr;
    assign unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};

    risc_v_alu_decoder u_alu_dec (
        .Funct3     (funct3),
        .Funct7b5   (funct7b5),
        .IsRType    (state_q == S_EXECR),
        .IsBranch   (state_q == S_BRANCH),
        .ALUControl (dec_alu)
    );

    assign stall    = (state_q inside {S_FETCH, S_MEMREAD, S_MEMWRITE}) && !MemReady;
    assign DbgState = state_q;

    // Next state and stall counter; the counter is zero everywhere except
    // during a run of stalled memory cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_FETCH:    if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_ERROR;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (MemReady) state_d = S_FETCH;
            S_EXECR,
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JALRWB;
            S_JALRWB:   state_d = S_FETCH;
            S_LUI:      state_d = S_FETCH;
            S_ERROR:    state_d = S_ERROR;
            default:    state_d = S_ERROR;
        endcase
        if (stall) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) state_d = S_ERROR;
        end
    end

    // State and stall counter registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore output decode; ERROR falls through to the all-zero defaults.
    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        ResultSrc  = RES_ALUOUT;
        ImmSrc     = IMM_I;
        ALUControl = ALU_ADD;
        InstrDone  = 1'b0;
        Fault      = (state_q == S_ERROR);
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = imm_src_for(opcode);
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_MEM;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                MemWrite  = 1'b1;
                InstrDone = MemReady;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_RD2;
                ALUControl = dec_alu;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_I;
                ALUControl = dec_alu;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_RD2;
                ALUControl = dec_alu;
                ResultSrc  = RES_ALUOUT;
                InstrDone  = 1'b1;
                case (funct3)
                    3'b000:  PCWrite = Zero;
                    3'b001:  PCWrite = !Zero;
                    3'b100:  PCWrite = Negative;
                    3'b101:  PCWrite = !Negative;
                    default: PCWrite = 1'b0;
                endcase
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALUOUT;
                ImmSrc    = IMM_J;
                PCWrite   = 1'b1;
            end
            S_JALR: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_I;
                ResultSrc = RES_ALURES;
                PCWrite   = 1'b1;
            end
            S_JALRWB: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_LUI: begin
                ImmSrc    = IMM_U;
                ResultSrc = RES_IMM;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_risc_v_mc_control.sv
// Cycle-by-cycle bench for the multicycle control FSM. Each row drives one
// cycle of inputs and pushes the full expected output vector; the vector is
// popped and compared at the following negedge.
module tb_risc_v_mc_control;
    import risc_v_pkg::*;

    localparam int W = 25;
    localparam int TB_STALL_LIMIT = 4;
    localparam logic [4:0] ADD = 5'b00010;

    logic        CLK = 1'b0;
    logic        ResetN;
    logic [31:0] Instr;
    logic        Zero, Negative, MemReady;
    logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0]  ImmSrc;
    logic [4:0]  ALUControl;
    logic        InstrDone, Fault;
    logic [3:0]  DbgState;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs;
    logic [W-1:0] exp_v;
    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0]  instr;
        logic         z;
        logic         n;
        logic         mr;
        logic [W-1:0] exp;
    } row_t;

    risc_v_mc_control #(.STALL_LIMIT(TB_STALL_LIMIT)) dut (
        .CLK(CLK), .ResetN(ResetN), .Instr(Instr), .Zero(Zero),
        .Negative(Negative), .MemReady(MemReady), .PCWrite(PCWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .InstrDone(InstrDone), .Fault(Fault), .DbgState(DbgState)
    );

    assign obs = {DbgState, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
                  ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl, InstrDone, Fault};

    // clock / watchdog
    always #5 CLK = ~CLK;
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1);
    end

    // en = {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc}
    function automatic logic [W-1:0] mk(input state_t st, input logic [4:0] en,
                                        input logic [1:0] sa, input logic [1:0] sb,
                                        input logic [1:0] rs, input logic [2:0] imm,
                                        input logic [4:0] alu, input logic done,
                                        input logic fault);
        return {st, en, sa, sb, rs, imm, alu, done, fault};
    endfunction

    function automatic row_t rw(input logic [31:0] i, input logic z, input logic n,
                                input logic mr, input logic [W-1:0] e);
        row_t r;
        r.instr = i; r.z = z; r.n = n; r.mr = mr; r.exp = e;
        return r;
    endfunction

    function automatic logic [W-1:0] v_fetch(input logic mr);
        return mk(S_FETCH, {mr, mr, 3'b000}, 2'b00, 2'b10, 2'b10, 3'b000, ADD, 1'b0, 1'b0);
    endfunction
    function automatic logic [W-1:0] v_decode(input logic [2:0] imm);
        return mk(S_DECODE, 5'b0, 2'b01, 2'b01, 2'b00, imm, ADD, 1'b0, 1'b0);
    endfunction
    function automatic logic [W-1:0] v_aluwb();
        return mk(S_ALUWB, 5'b00100, 2'b00, 2'b00, 2'b00, 3'b000, ADD, 1'b1, 1'b0);
    endfunction
    function automatic logic [W-1:0] v_error();
        return mk(S_ERROR, 5'b0, 2'b00, 2'b00, 2'b00, 3'b000, ADD, 1'b0, 1'b1);
    endfunction
    function automatic logic [W-1:0] v_memwrite(input logic mr);
        return mk(S_MEMWRITE, 5'b00011, 2'b00, 2'b00, 2'b00, 3'b000, ADD, mr, 1'b0);
    endfunction

    // driver tasks
    task automatic drive_row(input row_t r);
        Instr = r.instr; Zero = r.z; Negative = r.n; MemReady = r.mr;
        exp_q.push_back(r.exp);
        @(negedge CLK);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        ResetN = 1'b0; Instr = 32'h0; Zero = 1'b0; Negative = 1'b0; MemReady = 1'b0;
        drive_row(rw(32'h0, 1'b0, 1'b0, 1'b0, v_fetch(1'b0)));
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin
            n_fail++; $display("FAIL reset_hold: got %h expected %h", obs, exp_v);
        end
        step();
        ResetN = 1'b1;
        drive_row(rw(32'h0, 1'b0, 1'b0, 1'b0, v_fetch(1'b0)));
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin
            n_fail++; $display("FAIL reset_release: got %h expected %h", obs, exp_v);
        end
        step();
    endtask

    task automatic test_rtype();
        row_t rows[$];
        logic [31:0] ins [7] = '{32'h002081B3, 32'h402081B3, 32'h0020F1B3, 32'h0020E1B3,
                                 32'h002091B3, 32'h0020D1B3, 32'h0020A1B3};
        logic [4:0]  alu [7] = '{5'b00010, 5'b01010, 5'b00011, 5'b00111,
                                 5'b00000, 5'b10000, 5'b00001};
        for (int k = 0; k < 7; k++) begin
            rows.push_back(rw(ins[k], 1'b0, 1'b0, 1'b1, v_fetch(1'b1)));
            rows.push_back(rw(ins[k], 1'b0, 1'b0, 1'b1, v_decode(3'b000)));
            rows.push_back(rw(ins[k], 1'b0, 1'b0, 1'b1,
                mk(S_EXECR, 5'b0, 2'b10, 2'b00, 2'b00, 3'b000, alu[k], 1'b0, 1'b0)));
            rows.push_back(rw(ins[k], 1'b0, 1'b0, 1'b1, v_aluwb()));
        end
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_v = exp_q.pop_front(); n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL rtype cyc %0d: got %h expected %h", i, obs, exp_v);
            end
            step();
        end
    endtask

    task automatic test_itype();
        row_t rows[$];
        logic [31:0] ins [3] = '{32'h00500093, 32'h40008093, 32'h0FF0F093};
        logic [4:0]  alu [3] = '{5'b00010, 5'b00010, 5'b00011};
        // three stalled fetches stay below the limit of four
        for (int s = 0; s < 3; s++)
            rows.push_back(rw(ins[0], 1'b0, 1'b0, 1'b0, v_fetch(1'b0)));
        for (int k = 0; k < 3; k++) begin
            rows.push_back(rw(ins[k], 1'b0, 1'b0, 1'b1, v_fetch(1'b1)));
            rows.push_back(rw(ins[k], 1'b0, 1'b0, 1'b1, v_decode(3'b000)));
            rows.push_back(rw(ins[k], 1'b0, 1'b0, 1'b1,
                mk(S_EXECI, 5'b0, 2'b10, 2'b01, 2'b00, 3'b000, alu[k], 1'b0, 1'b0)));
            rows.push_back(rw(ins[k], 1'b0, 1'b0, 1'b1, v_aluwb()));
        end
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_v = exp_q.pop_front(); n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL itype cyc %0d: got %h expected %h", i, obs, exp_v);
            end
            step();
        end
    endtask

    task automatic test_load();
        row_t rows[$];
        logic [31:0] lw = 32'h0080A283;
        rows.push_back(rw(lw, 1'b0, 1'b0, 1'b1, v_fetch(1'b1)));
        rows.push_back(rw(lw, 1'b0, 1'b0, 1'b1, v_decode(3'b000)));
        rows.push_back(rw(lw, 1'b0, 1'b0, 1'b1,
            mk(S_MEMADR, 5'b0, 2'b10, 2'b01, 2'b00, 3'b000, ADD, 1'b0, 1'b0)));
        for (int s = 0; s < 4; s++)
            rows.push_back(rw(lw, 1'b0, 1'b0, (s == 3),
                mk(S_MEMREAD, 5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, ADD, 1'b0, 1'b0)));
        rows.push_back(rw(lw, 1'b0, 1'b0, 1'b1,
            mk(S_MEMWB, 5'b00100, 2'b00, 2'b00, 2'b01, 3'b000, ADD, 1'b1, 1'b0)));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_v = exp_q.pop_front(); n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL load cyc %0d: got %h expected %h", i, obs, exp_v);
            end
            step();
        end
    endtask

    task automatic test_store();
        row_t rows[$];
        logic [31:0] sw = 32'h0050A423;
        rows.push_back(rw(sw, 1'b0, 1'b0, 1'b1, v_fetch(1'b1)));
        rows.push_back(rw(sw, 1'b0, 1'b0, 1'b1, v_decode(3'b001)));
        rows.push_back(rw(sw, 1'b0, 1'b0, 1'b1,
            mk(S_MEMADR, 5'b0, 2'b10, 2'b01, 2'b00, 3'b001, ADD, 1'b0, 1'b0)));
        rows.push_back(rw(sw, 1'b0, 1'b0, 1'b0, v_memwrite(1'b0)));
        rows.push_back(rw(sw, 1'b0, 1'b0, 1'b0, v_memwrite(1'b0)));
        rows.push_back(rw(sw, 1'b0, 1'b0, 1'b1, v_memwrite(1'b1)));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_v = exp_q.pop_front(); n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL store cyc %0d: got %h expected %h", i, obs, exp_v);
            end
            step();
        end
    endtask

    task automatic test_branch();
        row_t rows[$];
        logic [31:0] ins [6] = '{32'h00208463, 32'h00208463, 32'h00209463,
                                 32'h0020C463, 32'h0020D463, 32'h0020D463};
        logic zf  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic nf  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic pcw [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 6; k++) begin
            rows.push_back(rw(ins[k], zf[k], nf[k], 1'b1, v_fetch(1'b1)));
            rows.push_back(rw(ins[k], zf[k], nf[k], 1'b1, v_decode(3'b010)));
            rows.push_back(rw(ins[k], zf[k], nf[k], 1'b1,
                mk(S_BRANCH, {pcw[k], 4'b0000}, 2'b10, 2'b00, 2'b00, 3'b000,
                   5'b01010, 1'b1, 1'b0)));
        end
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_v = exp_q.pop_front(); n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL branch cyc %0d: got %h expected %h", i, obs, exp_v);
            end
            step();
        end
    endtask

    task automatic test_jumps();
        row_t rows[$];
        logic [31:0] jal = 32'h008000EF, jalr = 32'h000080E7, lui = 32'h123450B7;
        rows.push_back(rw(jal, 1'b0, 1'b0, 1'b1, v_fetch(1'b1)));
        rows.push_back(rw(jal, 1'b0, 1'b0, 1'b1, v_decode(3'b100)));
        rows.push_back(rw(jal, 1'b0, 1'b0, 1'b1,
            mk(S_JAL, 5'b10000, 2'b01, 2'b10, 2'b00, 3'b100, ADD, 1'b0, 1'b0)));
        rows.push_back(rw(jal, 1'b0, 1'b0, 1'b1, v_aluwb()));
        rows.push_back(rw(jalr, 1'b0, 1'b0, 1'b1, v_fetch(1'b1)));
        rows.push_back(rw(jalr, 1'b0, 1'b0, 1'b1, v_decode(3'b000)));
        rows.push_back(rw(jalr, 1'b0, 1'b0, 1'b1,
            mk(S_JALR, 5'b10000, 2'b10, 2'b01, 2'b10, 3'b000, ADD, 1'b0, 1'b0)));
        rows.push_back(rw(jalr, 1'b0, 1'b0, 1'b1,
            mk(S_JALRWB, 5'b00100, 2'b01, 2'b10, 2'b10, 3'b000, ADD, 1'b1, 1'b0)));
        rows.push_back(rw(lui, 1'b0, 1'b0, 1'b1, v_fetch(1'b1)));
        rows.push_back(rw(lui, 1'b0, 1'b0, 1'b1, v_decode(3'b011)));
        rows.push_back(rw(lui, 1'b0, 1'b0, 1'b1,
            mk(S_LUI, 5'b00100, 2'b00, 2'b00, 2'b11, 3'b011, ADD, 1'b1, 1'b0)));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_v = exp_q.pop_front(); n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL jumps cyc %0d: got %h expected %h", i, obs, exp_v);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        for (int k = 0; k < 8; k++) begin
            int sel = $urandom_range(0, 2);
            logic z = 1'($urandom_range(0, 1));
            if (sel == 0) begin
                rows.push_back(rw(32'h123450B7, z, 1'b0, 1'b1, v_fetch(1'b1)));
                rows.push_back(rw(32'h123450B7, z, 1'b0, 1'b1, v_decode(3'b011)));
                rows.push_back(rw(32'h123450B7, z, 1'b0, 1'b1,
                    mk(S_LUI, 5'b00100, 2'b00, 2'b00, 2'b11, 3'b011, ADD, 1'b1, 1'b0)));
            end else if (sel == 1) begin
                rows.push_back(rw(32'h00209463, z, 1'b0, 1'b1, v_fetch(1'b1)));
                rows.push_back(rw(32'h00209463, z, 1'b0, 1'b1, v_decode(3'b010)));
                rows.push_back(rw(32'h00209463, z, 1'b0, 1'b1,
                    mk(S_BRANCH, {~z, 4'b0000}, 2'b10, 2'b00, 2'b00, 3'b000,
                       5'b01010, 1'b1, 1'b0)));
            end else begin
                rows.push_back(rw(32'h0020F1B3, z, 1'b0, 1'b1, v_fetch(1'b1)));
                rows.push_back(rw(32'h0020F1B3, z, 1'b0, 1'b1, v_decode(3'b000)));
                rows.push_back(rw(32'h0020F1B3, z, 1'b0, 1'b1,
                    mk(S_EXECR, 5'b0, 2'b10, 2'b00, 2'b00, 3'b000, 5'b00011, 1'b0, 1'b0)));
                rows.push_back(rw(32'h0020F1B3, z, 1'b0, 1'b1, v_aluwb()));
            end
        end
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_v = exp_q.pop_front(); n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL b2b cyc %0d: got %h expected %h", i, obs, exp_v);
            end
            step();
        end
    endtask

    task automatic test_error();
        row_t rows[$];
        rows.push_back(rw(32'h0000007F, 1'b0, 1'b0, 1'b1, v_fetch(1'b1)));
        rows.push_back(rw(32'h0000007F, 1'b0, 1'b0, 1'b1, v_decode(3'b000)));
        rows.push_back(rw(32'h0000007F, 1'b0, 1'b0, 1'b1, v_error()));
        rows.push_back(rw(32'h0000007F, 1'b0, 1'b0, 1'b0, v_error()));
        rows.push_back(rw(32'h002081B3, 1'b1, 1'b1, 1'b1, v_error()));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_v = exp_q.pop_front(); n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL error cyc %0d: got %h expected %h", i, obs, exp_v);
            end
            if (i < rows.size() - 1) step();
        end
        // asynchronous clear between clock edges
        MemReady = 1'b0;
        #2 ResetN = 1'b0;
        exp_q.push_back(v_fetch(1'b0));
        #1;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin
            n_fail++; $display("FAIL error_async_reset: got %h expected %h", obs, exp_v);
        end
        step();
        ResetN = 1'b1;
    endtask

    task automatic test_stall();
        row_t rows[$];
        for (int s = 0; s < TB_STALL_LIMIT; s++)
            rows.push_back(rw(32'h00500093, 1'b0, 1'b0, 1'b0, v_fetch(1'b0)));
        rows.push_back(rw(32'h00500093, 1'b0, 1'b0, 1'b1, v_error()));
        rows.push_back(rw(32'h00500093, 1'b0, 1'b0, 1'b1, v_error()));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_v = exp_q.pop_front(); n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL stall cyc %0d: got %h expected %h", i, obs, exp_v);
            end
            step();
        end
        MemReady = 1'b0;
        ResetN = 1'b0;
        step();
        ResetN = 1'b1;
    endtask

    task automatic test_reset_memwrite();
        row_t rows[$];
        logic [31:0] sw = 32'h0050A423, lui = 32'h123450B7;
        rows.push_back(rw(sw, 1'b0, 1'b0, 1'b1, v_fetch(1'b1)));
        rows.push_back(rw(sw, 1'b0, 1'b0, 1'b1, v_decode(3'b001)));
        rows.push_back(rw(sw, 1'b0, 1'b0, 1'b1,
            mk(S_MEMADR, 5'b0, 2'b10, 2'b01, 2'b00, 3'b001, ADD, 1'b0, 1'b0)));
        rows.push_back(rw(sw, 1'b0, 1'b0, 1'b0, v_memwrite(1'b0)));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_v = exp_q.pop_front(); n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL rst_mw cyc %0d: got %h expected %h", i, obs, exp_v);
            end
            if (i < rows.size() - 1) step();
        end
        #2 ResetN = 1'b0;
        exp_q.push_back(v_fetch(1'b0));
        #1;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (obs !== exp_v) begin
            n_fail++; $display("FAIL rst_mw_drop: got %h expected %h", obs, exp_v);
        end
        step();
        ResetN = 1'b1;
        rows.delete();
        rows.push_back(rw(lui, 1'b0, 1'b0, 1'b0, v_fetch(1'b0)));
        rows.push_back(rw(lui, 1'b0, 1'b0, 1'b1, v_fetch(1'b1)));
        rows.push_back(rw(lui, 1'b0, 1'b0, 1'b1, v_decode(3'b011)));
        rows.push_back(rw(lui, 1'b0, 1'b0, 1'b1,
            mk(S_LUI, 5'b00100, 2'b00, 2'b00, 2'b11, 3'b011, ADD, 1'b1, 1'b0)));
        foreach (rows[i]) begin
            drive_row(rows[i]);
            exp_v = exp_q.pop_front(); n_cmp++;
            if (obs !== exp_v) begin
                n_fail++; $display("FAIL rst_mw_resume cyc %0d: got %h expected %h", i, obs, exp_v);
            end
            step();
        end
    endtask

    // sequence and final report
    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_load();
        test_store();
        test_branch();
        test_jumps();
        test_back_to_back();
        test_error();
        test_stall();
        test_reset_memwrite();
        if (exp_q.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
